// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide sequencer: R-type opcode, MD funct codes,
// FSM state encoding and a conditional absolute-value helper.
package mdu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    // Two's-complement magnitude when the operation is signed and the value negative.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_seq_div_iter.sv
// One restoring shift-subtract divide step: shifts the next dividend bit from the
// quotient register into the partial remainder and produces one quotient bit.
module div_iter #(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] rem_i,
    input  logic [DW-1:0] quo_i,
    input  logic [DW-1:0] dvs_i,
    output logic [DW-1:0] rem_o,
    output logic [DW-1:0] quo_o
);

    logic [DW:0] shl_s;
    logic [DW:0] diff_s;

    // Trial subtraction; the top bit of the 33-bit difference is the borrow.
    always_comb begin
        shl_s  = {rem_i, quo_i[DW-1]};
        diff_s = shl_s - {1'b0, dvs_i};
        if (!diff_s[DW]) begin
            rem_o = diff_s[DW-1:0];
            quo_o = {quo_i[DW-2:0], 1'b1};
        end else begin
            rem_o = shl_s[DW-1:0];
            quo_o = {quo_i[DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer beside the EX-stage ALU; owns HI/LO and
// stalls the pipeline when an MD instruction arrives while an operation is in flight.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic          flush,
    input  logic [5:0]    op,
    input  logic [5:0]    funct,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    output logic          busy,
    output logic          stall,
    output logic [DW-1:0] mf_data,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    state_e          state_q;
    logic [4:0]      cnt_q;
    logic            busy_q;
    logic            sgn_q;
    logic [DW-1:0]   a_q, b_q;
    logic [DW-1:0]   rem_q, quo_q, dvs_q;
    logic [DW-1:0]   hi_q, lo_q;
    logic [DW-1:0]   rem_d, quo_d;
    logic            fn_md_s, is_md_s, accept_s, sgn_s;
    logic            neg_quo_s, neg_rem_s;
    logic [2*DW-1:0] prod_s;

    // Recognise the MD funct subset.
    always_comb begin
        fn_md_s = 1'b0;
        case (funct)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: fn_md_s = 1'b1;
            default:                            fn_md_s = 1'b0;
        endcase
    end

    assign is_md_s  = ex_valid & ~flush & (op == OP_RTYPE) & fn_md_s;
    assign accept_s = is_md_s & ~busy_q;
    assign sgn_s    = ~funct[0];
    assign stall    = busy_q & is_md_s;

    // Sign-extended 64x64 product; the low 64 bits equal the signed or unsigned result.
    assign prod_s    = {{DW{sgn_q & a_q[DW-1]}}, a_q} * {{DW{sgn_q & b_q[DW-1]}}, b_q};
    assign neg_quo_s = sgn_q & (a_q[DW-1] ^ b_q[DW-1]);
    assign neg_rem_s = sgn_q & a_q[DW-1];

    // Move-from read port, combinational from current HI/LO.
    always_comb begin
        mf_data = '0;
        if (is_md_s && funct == FN_MFHI) begin
            mf_data = hi_q;
        end else if (is_md_s && funct == FN_MFLO) begin
            mf_data = lo_q;
        end else begin
            mf_data = '0;
        end
    end

    div_iter #(.DW(DW)) u_div_iter (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Sequencer FSM with HI/LO, operand and iteration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        case (funct)
                            FN_MTHI: hi_q <= rs_data;
                            FN_MTLO: lo_q <= rs_data;
                            FN_MULT, FN_MULTU: begin
                                a_q     <= rs_data;
                                b_q     <= rt_data;
                                sgn_q   <= sgn_s;
                                cnt_q   <= 5'(MUL_CYCLES - 1);
                                busy_q  <= 1'b1;
                                state_q <= S_MUL;
                            end
                            FN_DIV, FN_DIVU: begin
                                a_q     <= rs_data;
                                b_q     <= rt_data;
                                sgn_q   <= sgn_s;
                                rem_q   <= '0;
                                quo_q   <= abs_if(rs_data, sgn_s);
                                dvs_q   <= abs_if(rt_data, sgn_s);
                                cnt_q   <= 5'd31;
                                busy_q  <= 1'b1;
                                state_q <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == 5'd0) begin
                        {hi_q, lo_q} <= prod_s;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == 5'd0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_FIX: begin
                    // Divide by zero reports all-ones quotient and the raw dividend.
                    if (b_q == '0) begin
                        lo_q <= {DW{1'b1}};
                        hi_q <= a_q;
                    end else begin
                        lo_q <= neg_quo_s ? ('0 - quo_q) : quo_q;
                        hi_q <= neg_rem_s ? ('0 - rem_q) : rem_q;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: multiply/divide results and latency,
// move-to/from HI/LO, stall qualification, back-to-back issue and mid-operation reset.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, ex_valid, flush;
    logic [5:0]  op, funct;
    logic [31:0] rs_data, rt_data;
    logic        busy, stall;
    logic [31:0] mf_data, hi, lo;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n;

    always #5 clk = ~clk;

    mdu_seq #(.MUL_CYCLES(4), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .flush    (flush),
        .op       (op),
        .funct    (funct),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .busy     (busy),
        .stall    (stall),
        .mf_data  (mf_data),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0;
        flush    = 1'b0;
        op       = 6'h00;
        funct    = 6'h00;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1;
        flush    = 1'b0;
        op       = OP_RTYPE;
        funct    = f;
        rs_data  = a;
        rt_data  = b;
    endtask

    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        drive(f, a, b);
        #1;
        check_eq({tag, " issue stall"}, {31'd0, stall}, 32'd0);
        tick();
        idle_in();
        wait_busy(c);
        check_eq({tag, " busy cycles"}, c, exp_cycles);
        check_eq({tag, " hi"}, hi, exp_hi);
        check_eq({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        check_eq("reset hi", hi, 32'h0);
        check_eq("reset lo", lo, 32'h0);
        check_eq("reset mf_data", mf_data, 32'h0);
        rst_n = 1'b1;

        // Signed multiply, then mflo held while the product is pending.
        drive(FN_MULT, 32'd7, 32'hFFFF_FFFD);
        #1;
        check_eq("mult issue stall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("mult busy c1", {31'd0, busy}, 32'd1);
        idle_in();
        tick();
        drive(FN_MFLO, 32'h0, 32'h0);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
        end
        check_eq("mflo stall cycles", n, 32'd3);
        check_eq("mflo data", mf_data, 32'hFFFF_FFEB);
        check_eq("mult hi", hi, 32'hFFFF_FFFF);
        check_eq("mult busy end", {31'd0, busy}, 32'd0);

        // New multiply issued in the cycle busy falls.
        run_op("multu", FN_MULTU, 32'hFFFF_FFFF, 32'd2, 4, 32'd1, 32'hFFFF_FFFE);
        run_op("div neg", FN_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", FN_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("divu by0", FN_DIVU, 32'h1234, 32'd0, 33, 32'h1234, 32'hFFFF_FFFF);
        run_op("div ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

        drive(FN_MTHI, 32'hA5A5_A5A5, 32'h0);
        #1;
        check_eq("mthi stall", {31'd0, stall}, 32'd0);
        tick();
        idle_in();
        check_eq("mthi hi", hi, 32'hA5A5_A5A5);
        check_eq("mthi busy", {31'd0, busy}, 32'd0);
        drive(FN_MTLO, 32'h5A5A_5A5A, 32'h0);
        tick();
        idle_in();
        check_eq("mtlo lo", lo, 32'h5A5A_5A5A);

        // Stall qualification during a divide, then a stalled mtlo accepted at busy fall.
        drive(FN_DIVU, 32'd100, 32'd7);
        tick();
        drive(FN_MFHI, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        check_eq("flushed mfhi stall", {31'd0, stall}, 32'd0);
        flush = 1'b0;
        funct = 6'h20;
        #1;
        check_eq("add stall", {31'd0, stall}, 32'd0);
        op    = 6'h08;
        funct = FN_MULT;
        #1;
        check_eq("non-rtype stall", {31'd0, stall}, 32'd0);
        drive(FN_MTLO, 32'h77, 32'h0);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
        end
        check_eq("mtlo stall cycles", n, 32'd33);
        check_eq("divu2 lo", lo, 32'd14);
        check_eq("divu2 hi", hi, 32'd2);
        tick();
        idle_in();
        check_eq("stalled mtlo lo", lo, 32'h77);

        // Reset in the middle of a divide.
        drive(FN_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        idle_in();
        repeat (9) tick();
        check_eq("pre-reset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midreset busy", {31'd0, busy}, 32'd0);
        check_eq("midreset hi", hi, 32'h0);
        check_eq("midreset lo", lo, 32'h0);
        run_op("mult post-reset", FN_MULT, 32'd3, 32'd5, 4, 32'h0, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
